// File: rtl/nvdla_periph_bridge.sv
// Cluster periph slave (req/gnt, ID-tagged responses) to NVDLA CSB register bridge.
// Optional feature macro: NVDLA_PERIPH_BRIDGE_ERR_EN (error responses for bad accesses).
module nvdla_periph_bridge #(
   parameter int unsigned ID_WIDTH = 10,
   parameter int unsigned CSB_AW   = 16,
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] WIN_BASE = 32'h0000_0000,
   parameter logic [31:0] WIN_SIZE = 32'h0004_0000
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   periph_req,
   output logic                   periph_gnt,
   input  logic [31:0]            periph_add,
   input  logic                   periph_wen,
   input  logic [3:0]             periph_be,
   input  logic [31:0]            periph_data,
   input  logic [ID_WIDTH-1:0]    periph_id,
   output logic                   periph_r_valid,
   output logic [31:0]            periph_r_data,
   output logic [ID_WIDTH-1:0]    periph_r_id,
   output logic                   csb_valid,
   input  logic                   csb_ready,
   output logic [CSB_AW-1:0]      csb_addr,
   output logic [31:0]            csb_wdat,
   output logic                   csb_write,
   input  logic                   csb_r_valid,
   input  logic [31:0]            csb_r_data,
   output logic [$clog2(DEPTH):0] outstanding_o,
   output logic                   err_o
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [31:0] ERR_DATA = 32'hBADA_CCE5;

   function automatic logic in_window(input logic [31:0] off);
      return off < WIN_SIZE;
   endfunction

   logic [31:0]         addr_off;
   logic                in_win;
   logic                req_err;
   logic                accept;
   logic                unused_bits;

   logic [CNT_W-1:0]    count;
   logic [PTR_W-1:0]    wptr;
   logic [PTR_W-1:0]    rptr;
   logic [ID_WIDTH-1:0] tag_id_mem [DEPTH];
   logic [DEPTH-1:0]    tag_is_rd;
   logic [DEPTH-1:0]    tag_is_err;

   logic [CNT_W-1:0]    rd_count;
   logic [PTR_W-1:0]    rd_wptr;
   logic [PTR_W-1:0]    rd_rptr;
   logic [31:0]         rd_mem [DEPTH];

   logic                tag_empty;
   logic                head_vld;
   logic [ID_WIDTH-1:0] head_id;
   logic                head_rd;
   logic                head_err;
   logic                rd_empty;
   logic                rd_avail;
   logic [31:0]         rd_head;
   logic                pop;
   logic                rd_pop;
   logic                tag_wr;
   logic                tag_rd_en;
   logic                rd_wr;
   logic                rd_rd;

   assign addr_off = periph_add - WIN_BASE;
   assign in_win   = in_window(addr_off);

`ifdef NVDLA_PERIPH_BRIDGE_ERR_EN
   assign req_err     = !in_win || (!periph_wen && (periph_be != 4'hF));
   assign unused_bits = &{1'b0, addr_off[31:CSB_AW+2], addr_off[1:0]};
`else
   assign req_err     = 1'b0;
   assign unused_bits = &{1'b0, in_win, periph_be, addr_off[31:CSB_AW+2], addr_off[1:0]};
`endif

   // Request path: full check uses the registered count, so a same-cycle pop never frees a slot.
   assign accept     = periph_req && (count != FULL_CNT) && !rst_i;
   assign csb_valid  = accept && !req_err;
   assign periph_gnt = accept && (req_err || csb_ready);
   assign csb_addr   = addr_off[CSB_AW+1:2];
   assign csb_wdat   = periph_data;
   assign csb_write  = !periph_wen;

   // Head of the tag FIFO, bypassed from the incoming grant when the FIFO is empty.
   assign tag_empty = (count == '0);
   assign head_vld  = !tag_empty || periph_gnt;
   assign head_id   = tag_empty ? periph_id  : tag_id_mem[rptr];
   assign head_rd   = tag_empty ? periph_wen : tag_is_rd[rptr];
   assign head_err  = tag_empty ? req_err    : tag_is_err[rptr];

   assign rd_empty  = (rd_count == '0);
   assign rd_avail  = !rd_empty || csb_r_valid;
   assign rd_head   = rd_empty ? csb_r_data : rd_mem[rd_rptr];

   assign pop       = head_vld && (head_err || !head_rd || rd_avail);
   assign rd_pop    = pop && head_rd && !head_err;

   assign tag_wr    = periph_gnt && !(tag_empty && pop);
   assign tag_rd_en = pop && !tag_empty;
   assign rd_wr     = csb_r_valid && !(rd_pop && rd_empty);
   assign rd_rd     = rd_pop && !rd_empty;

   assign outstanding_o = count;

   always_ff @(posedge clk_i) begin
      if (tag_wr) begin
         tag_id_mem[wptr] <= periph_id;
         tag_is_rd[wptr]  <= periph_wen;
         tag_is_err[wptr] <= req_err;
      end
      if (rd_wr) begin
         rd_mem[rd_wptr] <= csb_r_data;
      end
   end

   // Response stage: one registered response per cycle, in grant order.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count          <= '0;
         wptr           <= '0;
         rptr           <= '0;
         rd_count       <= '0;
         rd_wptr        <= '0;
         rd_rptr        <= '0;
         periph_r_valid <= 1'b0;
         periph_r_data  <= '0;
         periph_r_id    <= '0;
      end else begin
         if (tag_wr) begin
            wptr <= wptr + PTR_W'(1);
         end
         if (tag_rd_en) begin
            rptr <= rptr + PTR_W'(1);
         end
         count <= count + CNT_W'(tag_wr) - CNT_W'(tag_rd_en);

         if (rd_wr) begin
            rd_wptr <= rd_wptr + PTR_W'(1);
         end
         if (rd_rd) begin
            rd_rptr <= rd_rptr + PTR_W'(1);
         end
         rd_count <= rd_count + CNT_W'(rd_wr) - CNT_W'(rd_rd);

         periph_r_valid <= pop;
         if (pop) begin
            periph_r_id   <= head_id;
            periph_r_data <= head_err ? ERR_DATA : (head_rd ? rd_head : 32'h0);
         end
      end
   end

`ifdef NVDLA_PERIPH_BRIDGE_ERR_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         err_o <= 1'b0;
      end else begin
         err_o <= pop && head_err;
      end
   end
`else
   assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_nvdla_periph_bridge.sv
// Directed scoreboard bench for nvdla_periph_bridge (default parameters).
`timescale 1ns/1ps
module tb_nvdla_periph_bridge;
   localparam int ID_W  = 10;
   localparam int AW    = 16;
   localparam int DEPTH = 4;
   localparam logic [31:0] WIN_BASE = 32'h0000_0000;
   localparam logic [31:0] WIN_SIZE = 32'h0004_0000;

   logic            clk = 1'b0;
   logic            rst_i;
   logic            periph_req;
   logic            periph_gnt;
   logic [31:0]     periph_add;
   logic            periph_wen;
   logic [3:0]      periph_be;
   logic [31:0]     periph_data;
   logic [ID_W-1:0] periph_id;
   logic            periph_r_valid;
   logic [31:0]     periph_r_data;
   logic [ID_W-1:0] periph_r_id;
   logic            csb_valid;
   logic            csb_ready;
   logic [AW-1:0]   csb_addr;
   logic [31:0]     csb_wdat;
   logic            csb_write;
   logic            csb_r_valid;
   logic [31:0]     csb_r_data;
   logic [2:0]      outstanding_o;
   logic            err_o;

   nvdla_periph_bridge #(
      .ID_WIDTH(ID_W), .CSB_AW(AW), .DEPTH(DEPTH), .WIN_BASE(WIN_BASE), .WIN_SIZE(WIN_SIZE)
   ) dut (
      .clk_i(clk), .rst_i(rst_i),
      .periph_req(periph_req), .periph_gnt(periph_gnt), .periph_add(periph_add),
      .periph_wen(periph_wen), .periph_be(periph_be), .periph_data(periph_data),
      .periph_id(periph_id), .periph_r_valid(periph_r_valid), .periph_r_data(periph_r_data),
      .periph_r_id(periph_r_id), .csb_valid(csb_valid), .csb_ready(csb_ready),
      .csb_addr(csb_addr), .csb_wdat(csb_wdat), .csb_write(csb_write),
      .csb_r_valid(csb_r_valid), .csb_r_data(csb_r_data),
      .outstanding_o(outstanding_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [ID_W-1:0] id;
      logic [31:0]     data;
      logic            err;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   vectors = 0;
   int   miscompares = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard consumer: every response must match the oldest expected entry.
   always @(negedge clk) begin
      if (rst_i === 1'b0) begin
         if (periph_r_valid === 1'b1) begin
            if (sb.size() == 0) begin
               check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
               mon_e = sb.pop_front();
               check("rsp_id", 32'(periph_r_id), 32'(mon_e.id));
               check("rsp_data", periph_r_data, mon_e.data);
               check("rsp_err", 32'(err_o), 32'(mon_e.err));
            end
         end else begin
            check("err_idle", 32'(err_o), 32'd0);
         end
      end
   end

   task automatic do_req(input logic [31:0] add, input logic wen, input logic [3:0] be,
                         input logic [31:0] data, input logic [ID_W-1:0] id,
                         input logic [31:0] rdata, input logic err);
      exp_t        e;
      bit          granted;
      logic [31:0] off;
      granted     = 1'b0;
      off         = add - WIN_BASE;
      periph_req  = 1'b1;
      periph_add  = add;
      periph_wen  = wen;
      periph_be   = be;
      periph_data = data;
      periph_id   = id;
      for (int i = 0; i < 20 && !granted; i++) begin
         @(negedge clk);
         if (periph_gnt === 1'b1) begin
            granted = 1'b1;
            e.id    = id;
            e.data  = err ? 32'hBADACCE5 : (wen ? rdata : 32'h0);
            e.err   = err;
            sb.push_back(e);
            if (err) begin
               check("err_no_csb_valid", 32'(csb_valid), 32'd0);
            end else begin
               check("csb_valid", 32'(csb_valid), 32'd1);
               check("csb_addr", 32'(csb_addr), 32'(off[AW+1:2]));
               check("csb_write", 32'(csb_write), 32'(!wen));
               if (!wen) check("csb_wdat", csb_wdat, data);
            end
         end
         nxt();
      end
      if (!granted) check("gnt_timeout", 32'd0, 32'd1);
      periph_req = 1'b0;
   endtask

   initial begin
      rst_i = 1'b1; periph_req = 1'b0; periph_add = '0; periph_wen = 1'b0;
      periph_be = 4'hF; periph_data = '0; periph_id = '0;
      csb_ready = 1'b0; csb_r_valid = 1'b0; csb_r_data = '0;

      // Reset state, with a request pending to show gnt is held low
      repeat (2) nxt();
      periph_req = 1'b1; periph_add = 32'h100; csb_ready = 1'b1;
      @(negedge clk);
      check("rst_gnt", 32'(periph_gnt), 32'd0);
      check("rst_rvalid", 32'(periph_r_valid), 32'd0);
      check("rst_rdata", periph_r_data, 32'd0);
      check("rst_rid", 32'(periph_r_id), 32'd0);
      check("rst_outstanding", 32'(outstanding_o), 32'd0);
      check("rst_err", 32'(err_o), 32'd0);
      nxt();
      periph_req = 1'b0; rst_i = 1'b0;
      nxt();

      // Single write, first with CSB back-pressure
      periph_req = 1'b1; periph_add = 32'h100; periph_wen = 1'b0; periph_be = 4'hF;
      periph_data = 32'hCAFE0001; periph_id = 10'd3; csb_ready = 1'b0;
      @(negedge clk);
      check("bp_csb_valid", 32'(csb_valid), 32'd1);
      check("bp_gnt", 32'(periph_gnt), 32'd0);
      nxt();
      csb_ready = 1'b1;
      do_req(32'h100, 1'b0, 4'hF, 32'hCAFE0001, 10'd3, 32'h0, 1'b0);
      @(negedge clk);
      check("wr_rvalid_t1", 32'(periph_r_valid), 32'd1);
      check("wr_outstanding", 32'(outstanding_o), 32'd0);
      nxt();
      @(negedge clk);
      check("wr_rvalid_pulse", 32'(periph_r_valid), 32'd0);
      nxt();

      // Single read, data three cycles after grant
      do_req(32'h104, 1'b1, 4'hF, 32'h0, 10'd5, 32'h12345678, 1'b0);
      @(negedge clk);
      check("rd_outstanding", 32'(outstanding_o), 32'd1);
      check("rd_wait", 32'(periph_r_valid), 32'd0);
      nxt();
      nxt();
      csb_r_valid = 1'b1; csb_r_data = 32'h12345678;
      @(negedge clk);
      check("rd_not_yet", 32'(periph_r_valid), 32'd0);
      nxt();
      csb_r_valid = 1'b0;
      @(negedge clk);
      check("rd_rvalid", 32'(periph_r_valid), 32'd1);
      check("rd_outstanding_0", 32'(outstanding_o), 32'd0);
      nxt();

      // Ordering: write response held behind an older slow read
      do_req(32'h200, 1'b1, 4'hF, 32'h0, 10'd1, 32'hAAAA5555, 1'b0);
      do_req(32'h204, 1'b0, 4'hF, 32'h11112222, 10'd2, 32'h0, 1'b0);
      @(negedge clk);
      check("ord_outstanding", 32'(outstanding_o), 32'd2);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("ord_hold", 32'(periph_r_valid), 32'd0);
         nxt();
      end
      csb_r_valid = 1'b1; csb_r_data = 32'hAAAA5555;
      @(negedge clk);
      check("ord_hold_last", 32'(periph_r_valid), 32'd0);
      nxt();
      csb_r_valid = 1'b0;
      @(negedge clk);
      check("ord_first", 32'(periph_r_id), 32'd1);
      nxt();
      @(negedge clk);
      check("ord_second_valid", 32'(periph_r_valid), 32'd1);
      check("ord_second", 32'(periph_r_id), 32'd2);
      check("ord_outstanding_0", 32'(outstanding_o), 32'd0);
      nxt();

      // Full: four reads outstanding, fifth waits for a slot
      for (int i = 0; i < 4; i++) begin
         do_req(32'h300 + 32'(4 * i), 1'b1, 4'hF, 32'h0, 10'(10 + i), 32'hD000_0000 + 32'(i), 1'b0);
      end
      periph_req = 1'b1; periph_add = 32'h310; periph_wen = 1'b1; periph_id = 10'd14;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("full_gnt", 32'(periph_gnt), 32'd0);
         check("full_outstanding", 32'(outstanding_o), 32'd4);
         nxt();
      end
      csb_r_valid = 1'b1; csb_r_data = 32'hD000_0000;
      @(negedge clk);
      check("full_same_cycle_pop", 32'(periph_gnt), 32'd0);
      nxt();
      csb_r_valid = 1'b0;
      @(negedge clk);
      check("full_regrant", 32'(periph_gnt), 32'd1);
      check("full_outstanding_3", 32'(outstanding_o), 32'd3);
      if (periph_gnt === 1'b1) sb.push_back('{id: 10'd14, data: 32'hD000_0004, err: 1'b0});
      nxt();
      periph_req = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         csb_r_valid = 1'b1; csb_r_data = 32'hD000_0000 + 32'(i);
         nxt();
      end
      csb_r_valid = 1'b0;
      for (int i = 0; i < 10 && sb.size() != 0; i++) nxt();
      check("full_drain", 32'(sb.size()), 32'd0);
      check("full_outstanding_0", 32'(outstanding_o), 32'd0);

      // Asynchronous reset while a response and a grant are live
      do_req(32'h400, 1'b1, 4'hF, 32'h0, 10'd20, 32'hE000_0000, 1'b0);
      do_req(32'h404, 1'b1, 4'hF, 32'h0, 10'd21, 32'hE000_0001, 1'b0);
      @(negedge clk);
      check("rst_mid_outstanding", 32'(outstanding_o), 32'd2);
      nxt();
      csb_r_valid = 1'b1; csb_r_data = 32'hE000_0000;
      nxt();
      csb_r_valid = 1'b0;
      periph_req = 1'b1; periph_add = 32'h408; periph_wen = 1'b1; periph_id = 10'd23;
      #2;
      check("rst_pre_rvalid", 32'(periph_r_valid), 32'd1);
      check("rst_pre_gnt", 32'(periph_gnt), 32'd1);
      rst_i = 1'b1;
      #1;
      check("rst_async_rvalid", 32'(periph_r_valid), 32'd0);
      check("rst_async_gnt", 32'(periph_gnt), 32'd0);
      check("rst_async_outstanding", 32'(outstanding_o), 32'd0);
      check("rst_async_rdata", periph_r_data, 32'd0);
      sb.delete();
      periph_req = 1'b0;
      nxt();
      nxt();
      rst_i = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("post_rst_quiet", 32'(periph_r_valid), 32'd0);
         nxt();
      end
      check("post_rst_outstanding", 32'(outstanding_o), 32'd0);

`ifdef NVDLA_PERIPH_BRIDGE_ERR_EN
      // Partial-byte write and out-of-window read answered with error data
      do_req(32'h10, 1'b0, 4'h3, 32'h55, 10'd30, 32'h0, 1'b1);
      do_req(32'h0005_0000, 1'b1, 4'hF, 32'h0, 10'd31, 32'h0, 1'b1);
      @(negedge clk);
      check("err_second_valid", 32'(periph_r_valid), 32'd1);
      check("err_second_pulse", 32'(err_o), 32'd1);
      nxt();
      @(negedge clk);
      check("err_pulse_end", 32'(err_o), 32'd0);
      nxt();
`else
      // Without error checking, partial writes and out-of-window reads are forwarded
      do_req(32'h10, 1'b0, 4'h3, 32'h55, 10'd30, 32'h0, 1'b0);
      do_req(32'h0005_0000, 1'b1, 4'hF, 32'h0, 10'd31, 32'h600D_F00D, 1'b0);
      nxt();
      csb_r_valid = 1'b1; csb_r_data = 32'h600D_F00D;
      nxt();
      csb_r_valid = 1'b0;
      @(negedge clk);
      check("fwd_rvalid", 32'(periph_r_valid), 32'd1);
      check("fwd_err", 32'(err_o), 32'd0);
      nxt();
`endif

      for (int i = 0; i < 10 && sb.size() != 0; i++) nxt();
      check("final_drain", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
